dram_arbiter: RTL and testbench

Two-requester arbiter sharing the single-port `dram` between the CPU data port (MEM/EX stage load/store traffic, requester 0) and a second master (debug/DMA loader, requester 1). Each cycle at most one request is granted and driven onto the DRAM port. Read data is routed back to the requester that issued it one cycle later. Sits between `cpu`'s data-side signals and `dram`, so `dram` stays unmodified.

---
 rtl/dram_arbiter.sv | 145 ++++++++++++++
 tb/tb_dram_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// dram_arbiter
// Shares the single-port DRAM between the CPU data port (requester 0) and a
// debug/DMA loader (requester 1). At most one request is granted each cycle,
// and that request drives the DRAM port. Load data returns to the requester
// that issued it one cycle later.
//
// Parameters:
//   RR_MODE      0 = requester 0 has fixed priority, with anti-starvation for
//                    requester 1; 1 = strict round-robin
//   STARVE_LIMIT consecutive denied cycles after which requester 1 is promoted
//                (1..255, only used when RR_MODE = 0)
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   mX_req/we/op/adr/wdata  requester X access, held stable until granted
//   mX_gnt                  combinational grant; the transfer happens at the
//                           edge where req and gnt are both high
//   mX_rvalid/rdata         load response, one cycle after acceptance
//   dram_adr/w_op/we/wdin   to the DRAM
//   dram_rdi                read data from the DRAM, valid the cycle after
//                           the address is presented
module dram_arbiter #(
    parameter int RR_MODE      = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_op,
    input  logic [31:0] m0_adr,
    input  logic [31:0] m0_wdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_op,
    input  logic [31:0] m1_adr,
    input  logic [31:0] m1_wdata,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic [31:0] dram_adr,
    output logic [1:0]  dram_w_op,
    output logic        dram_we,
    output logic [31:0] dram_wdin,
    input  logic [31:0] dram_rdi
);

    logic       last_gnt;
    logic [7:0] wait_cnt;
    logic       rsp_pend;
    logic       rsp_id;

    logic       gnt0;
    logic       gnt1;
    logic       starved;

    assign starved = (wait_cnt >= 8'(STARVE_LIMIT));

    // Grant selection. Grants are held low during reset so that nothing can
    // reach the DRAM while the arbiter state is invalid.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (m0_req && !m1_req) begin
                gnt0 = 1'b1;
            end else if (m1_req && !m0_req) begin
                gnt1 = 1'b1;
            end else if (m0_req && m1_req) begin
                if (RR_MODE != 0) begin
                    // The requester that was not served last wins the tie.
                    gnt0 = last_gnt;
                    gnt1 = !last_gnt;
                end else begin
                    gnt0 = !starved;
                    gnt1 = starved;
                end
            end
        end
    end

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

    // DRAM mux. With no grant every field is zero, so no store can be
    // written spuriously.
    always_comb begin
        dram_adr  = 32'h0;
        dram_w_op = 2'b00;
        dram_we   = 1'b0;
        dram_wdin = 32'h0;
        if (gnt0) begin
            dram_adr  = m0_adr;
            dram_w_op = m0_op;
            dram_we   = m0_we;
            dram_wdin = m0_wdata;
        end else if (gnt1) begin
            dram_adr  = m1_adr;
            dram_w_op = m1_op;
            dram_we   = m1_we;
            dram_wdin = m1_wdata;
        end
    end

    // Arbitration and response state. rsp_pend marks a load that was
    // accepted at the last edge; rsp_id records who issued it, so that
    // back-to-back loads from alternating requesters each route correctly.
    // wait_cnt counts consecutive cycles in which requester 1 was denied,
    // and saturates at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
            wait_cnt <= 8'h00;
            rsp_pend <= 1'b0;
            rsp_id   <= 1'b0;
        end else begin
            if (gnt0 || gnt1) begin
                last_gnt <= gnt1;
                rsp_id   <= gnt1;
                rsp_pend <= gnt1 ? !m1_we : !m0_we;
            end else begin
                rsp_pend <= 1'b0;
            end

            if (m1_req && !gnt1) begin
                if (wait_cnt != 8'hFF) begin
                    wait_cnt <= wait_cnt + 8'h01;
                end
            end else begin
                wait_cnt <= 8'h00;
            end
        end
    end

    // The response comes straight from registers, so asserting reset clears
    // it immediately and a pending load is discarded.
    assign m0_rvalid = rsp_pend && !rsp_id;
    assign m1_rvalid = rsp_pend && rsp_id;
    assign m0_rdata  = m0_rvalid ? dram_rdi : 32'h0;
    assign m1_rdata  = m1_rvalid ? dram_rdi : 32'h0;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter
// Directed bench for dram_arbiter. Two instances share the same requester
// stimulus: uRr (round-robin) and uFp (fixed priority with STARVE_LIMIT=4).
// Each instance has its own small word-addressed DRAM model with a one-cycle
// registered read.
module tb_dram_arbiter;

    logic        clk = 1'b0;
    logic        rstN;
    logic        m0Req, m0We, m1Req, m1We;
    logic [1:0]  m0Op, m1Op;
    logic [31:0] m0Adr, m0Wdata, m1Adr, m1Wdata;

    logic        rrM0Gnt, rrM1Gnt, rrM0Rvalid, rrM1Rvalid, rrDramWe;
    logic [31:0] rrM0Rdata, rrM1Rdata, rrDramAdr, rrDramWdin, rrDramRdi;
    logic [1:0]  rrDramOp;

    logic        fpM0Gnt, fpM1Gnt, fpM0Rvalid, fpM1Rvalid, fpDramWe;
    logic [31:0] fpM0Rdata, fpM1Rdata, fpDramAdr, fpDramWdin, fpDramRdi;
    logic [1:0]  fpDramOp;

    int testCount = 0;
    int failCount = 0;

    localparam logic [31:0] DataA = 32'hDEADBEEF;
    localparam logic [31:0] DataB = 32'hCAFE0020;

    logic [31:0] memRr [0:63] = '{4: 32'hDEADBEEF, 8: 32'hCAFE0020, default: 32'h0};
    logic [31:0] memFp [0:63] = '{4: 32'hDEADBEEF, 8: 32'hCAFE0020, default: 32'h0};

    always #5 clk = ~clk;

    dram_arbiter #(.RR_MODE(1), .STARVE_LIMIT(4)) uRr (
        .clk(clk), .rst_n(rstN),
        .m0_req(m0Req), .m0_we(m0We), .m0_op(m0Op), .m0_adr(m0Adr), .m0_wdata(m0Wdata),
        .m1_req(m1Req), .m1_we(m1We), .m1_op(m1Op), .m1_adr(m1Adr), .m1_wdata(m1Wdata),
        .m0_gnt(rrM0Gnt), .m1_gnt(rrM1Gnt),
        .m0_rvalid(rrM0Rvalid), .m1_rvalid(rrM1Rvalid),
        .m0_rdata(rrM0Rdata), .m1_rdata(rrM1Rdata),
        .dram_adr(rrDramAdr), .dram_w_op(rrDramOp), .dram_we(rrDramWe),
        .dram_wdin(rrDramWdin), .dram_rdi(rrDramRdi)
    );

    dram_arbiter #(.RR_MODE(0), .STARVE_LIMIT(4)) uFp (
        .clk(clk), .rst_n(rstN),
        .m0_req(m0Req), .m0_we(m0We), .m0_op(m0Op), .m0_adr(m0Adr), .m0_wdata(m0Wdata),
        .m1_req(m1Req), .m1_we(m1We), .m1_op(m1Op), .m1_adr(m1Adr), .m1_wdata(m1Wdata),
        .m0_gnt(fpM0Gnt), .m1_gnt(fpM1Gnt),
        .m0_rvalid(fpM0Rvalid), .m1_rvalid(fpM1Rvalid),
        .m0_rdata(fpM0Rdata), .m1_rdata(fpM1Rdata),
        .dram_adr(fpDramAdr), .dram_w_op(fpDramOp), .dram_we(fpDramWe),
        .dram_wdin(fpDramWdin), .dram_rdi(fpDramRdi)
    );

    // DRAM models: a store is written at the accepting edge, and read data
    // for the presented address appears in the following cycle.
    always @(posedge clk) begin
        if (rrDramWe) memRr[rrDramAdr[7:2]] <= rrDramWdin;
        rrDramRdi <= memRr[rrDramAdr[7:2]];
    end

    always @(posedge clk) begin
        if (fpDramWe) memFp[fpDramAdr[7:2]] <= fpDramWdin;
        fpDramRdi <= memFp[fpDramAdr[7:2]];
    end

    // One comparison: count it, and report it if it differs.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive every requester field for both masters in one call.
    task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0,
                                 input logic r1, input logic w1, input logic [31:0] a1,
                                 input logic [31:0] d1);
        m0Req = r0; m0We = w0; m0Op = 2'b10; m0Adr = a0; m0Wdata = 32'h0;
        m1Req = r1; m1We = w1; m1Op = 2'b10; m1Adr = a1; m1Wdata = d1;
    endtask

    // Directed sequence: reset, continuous contention (round-robin and
    // anti-starvation at the same time), idle, store-then-load, and reset
    // in the middle of a load.
    initial begin
        int fpGnt [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int fpWait[10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
        int rrPrev;
        int fpPrev;

        rstN = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);

        // Reset held with both requesting (m0 is a store): nothing is granted.
        @(negedge clk); #1;
        checkOutput("rst_rr_m0_gnt", 32'(rrM0Gnt), 32'd0);
        checkOutput("rst_rr_m1_gnt", 32'(rrM1Gnt), 32'd0);
        checkOutput("rst_fp_m0_gnt", 32'(fpM0Gnt), 32'd0);
        checkOutput("rst_fp_dram_we", 32'(fpDramWe), 32'd0);
        checkOutput("rst_rr_rvalid", {30'd0, rrM1Rvalid, rrM0Rvalid}, 32'd0);
        checkOutput("rst_fp_rvalid", {30'd0, fpM1Rvalid, fpM0Rvalid}, 32'd0);

        // Continuous loads from both: m0 at 0x10 (DEADBEEF), m1 at 0x20.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                rstN = 1'b1;
                m0We = 1'b0;
            end
            #1;
            checkOutput($sformatf("rr_m0_gnt_%0d", i), 32'(rrM0Gnt), 32'((i % 2) == 0));
            checkOutput($sformatf("rr_m1_gnt_%0d", i), 32'(rrM1Gnt), 32'((i % 2) == 1));
            checkOutput($sformatf("fp_m0_gnt_%0d", i), 32'(fpM0Gnt), 32'(fpGnt[i] == 0));
            checkOutput($sformatf("fp_m1_gnt_%0d", i), 32'(fpM1Gnt), 32'(fpGnt[i] == 1));
            checkOutput($sformatf("fp_wait_%0d", i), 32'(uFp.wait_cnt), 32'(fpWait[i]));
            if (i > 0) begin
                rrPrev = (i - 1) % 2;
                fpPrev = fpGnt[i - 1];
                checkOutput($sformatf("rr_m0_rvalid_%0d", i), 32'(rrM0Rvalid), 32'(rrPrev == 0));
                checkOutput($sformatf("rr_m1_rvalid_%0d", i), 32'(rrM1Rvalid), 32'(rrPrev == 1));
                checkOutput($sformatf("rr_m0_rdata_%0d", i), rrM0Rdata, (rrPrev == 0) ? DataA : 32'h0);
                checkOutput($sformatf("rr_m1_rdata_%0d", i), rrM1Rdata, (rrPrev == 1) ? DataB : 32'h0);
                checkOutput($sformatf("fp_m0_rvalid_%0d", i), 32'(fpM0Rvalid), 32'(fpPrev == 0));
                checkOutput($sformatf("fp_m1_rvalid_%0d", i), 32'(fpM1Rvalid), 32'(fpPrev == 1));
                checkOutput($sformatf("fp_m0_rdata_%0d", i), fpM0Rdata, (fpPrev == 0) ? DataA : 32'h0);
                checkOutput($sformatf("fp_m1_rdata_%0d", i), fpM1Rdata, (fpPrev == 1) ? DataB : 32'h0);
            end
        end

        // Idle: the last grant in both instances was m1, so its response
        // shows up now while the DRAM port reads all zero.
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 32'h20, 32'h0);
        #1;
        checkOutput("idle_gnt", {28'd0, fpM1Gnt, fpM0Gnt, rrM1Gnt, rrM0Gnt}, 32'd0);
        checkOutput("idle_dram_adr", fpDramAdr, 32'h0);
        checkOutput("idle_dram_we", 32'(fpDramWe), 32'd0);
        checkOutput("idle_rr_m1_rdata", rrM1Rdata, DataB);
        checkOutput("idle_fp_m1_rdata", fpM1Rdata, DataB);
        checkOutput("idle_fp_m0_rvalid", 32'(fpM0Rvalid), 32'd0);

        // m1 stores 0x12345678 to 0x40.
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h10, 1'b1, 1'b1, 32'h40, 32'h12345678);
        #1;
        checkOutput("st_rr_m1_gnt", 32'(rrM1Gnt), 32'd1);
        checkOutput("st_fp_m1_gnt", 32'(fpM1Gnt), 32'd1);
        checkOutput("st_dram_we", 32'(fpDramWe), 32'd1);
        checkOutput("st_dram_adr", fpDramAdr, 32'h40);
        checkOutput("st_dram_wdin", fpDramWdin, 32'h12345678);
        checkOutput("st_dram_op", 32'(fpDramOp), 32'd2);

        // m0 loads 0x40; the store raised no response.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 32'h40, 32'h0);
        #1;
        checkOutput("ld_fp_m0_gnt", 32'(fpM0Gnt), 32'd1);
        checkOutput("st_no_rvalid", {28'd0, fpM1Rvalid, fpM0Rvalid, rrM1Rvalid, rrM0Rvalid}, 32'd0);
        checkOutput("ld_dram_adr", fpDramAdr, 32'h40);

        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h40, 1'b0, 1'b0, 32'h40, 32'h0);
        #1;
        checkOutput("ld_fp_m0_rdata", fpM0Rdata, 32'h12345678);
        checkOutput("ld_rr_m0_rdata", rrM0Rdata, 32'h12345678);
        checkOutput("ld_fp_m0_rvalid", 32'(fpM0Rvalid), 32'd1);

        // Reset mid-transfer: both request loads; fixed priority takes m0,
        // round-robin takes m1 (m0 was served last).
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
        #1;
        checkOutput("mid_fp_m0_gnt", 32'(fpM0Gnt), 32'd1);
        checkOutput("mid_rr_m1_gnt", 32'(rrM1Gnt), 32'd1);
        @(posedge clk); #1;
        checkOutput("mid_fp_m0_rvalid_pre", 32'(fpM0Rvalid), 32'd1);
        checkOutput("mid_fp_wait_pre", 32'(uFp.wait_cnt), 32'd1);
        #1 rstN = 1'b0;
        #1;
        checkOutput("mid_fp_m0_rvalid", 32'(fpM0Rvalid), 32'd0);
        checkOutput("mid_rr_m1_rvalid", 32'(rrM1Rvalid), 32'd0);
        checkOutput("mid_fp_wait", 32'(uFp.wait_cnt), 32'd0);
        checkOutput("mid_fp_last_gnt", 32'(uFp.last_gnt), 32'd1);
        checkOutput("mid_rr_last_gnt", 32'(uRr.last_gnt), 32'd1);
        checkOutput("mid_gnt_forced", {28'd0, fpM1Gnt, fpM0Gnt, rrM1Gnt, rrM0Gnt}, 32'd0);
        checkOutput("mid_dram_we", 32'(fpDramWe), 32'd0);

        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 32'h20, 32'h0);
        rstN = 1'b1;
        @(negedge clk); #1;
        checkOutput("post_fp_last_gnt", 32'(uFp.last_gnt), 32'd1);
        checkOutput("post_fp_wait", 32'(uFp.wait_cnt), 32'd0);
        checkOutput("post_fp_m0_rvalid", 32'(fpM0Rvalid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
